// File: rtl/spi_pkg.sv
// Shared register map, field positions and APB FSM encoding for the SPI FIFO register block.
package spi_pkg;

  // Word offsets within the 256-byte register window
  localparam logic [7:0] OFF_CR1 = 8'h00;
  localparam logic [7:0] OFF_CR2 = 8'h04;
  localparam logic [7:0] OFF_BR  = 8'h08;
  localparam logic [7:0] OFF_SR  = 8'h0C;
  localparam logic [7:0] OFF_DR  = 8'h10;
  localparam logic [7:0] OFF_LVL = 8'h14;
  localparam logic [7:0] OFF_ISR = 8'h18;
  localparam logic [7:0] OFF_IER = 8'h1C;
  localparam logic [7:0] OFF_THR = 8'h20;
  localparam logic [7:0] OFF_MAX = OFF_THR;

  // Reset values and implemented-bit masks
  localparam logic [7:0] CR1_RST  = 8'h10;
  localparam logic [7:0] CR2_MASK = 8'hE3;
  localparam logic [7:0] BR_MASK  = 8'h77;
  localparam logic [7:0] RX_THR_RST = 8'h01;

  // CR2 / BR fields
  localparam int CR2_SPIE    = 7;
  localparam int CR2_SPTIE   = 6;
  localparam int CR2_ERRIE   = 5;
  localparam int CR2_BIDIROE = 1;
  localparam int CR2_SPC0    = 0;
  localparam int BR_SPPR_LSB = 4;
  localparam int BR_SPR_LSB  = 0;

  // SR fields
  localparam int SR_TX_EMPTY = 0;
  localparam int SR_TX_FULL  = 1;
  localparam int SR_RX_EMPTY = 2;
  localparam int SR_RX_FULL  = 3;

  // LVL / THR field LSBs
  localparam int LVL_TX_LSB = 0;
  localparam int LVL_RX_LSB = 16;
  localparam int THR_TX_LSB = 0;
  localparam int THR_RX_LSB = 16;

  // ISR bits: [1:0] live levels, [5:2] sticky events
  localparam int ISR_TX_LVL = 0;
  localparam int ISR_RX_LVL = 1;
  localparam int ISR_RX_OVR = 2;
  localparam int ISR_TX_OVF = 3;
  localparam int ISR_RX_UDF = 4;
  localparam int ISR_MODF   = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } apb_state_e;

  // Response computed at the access edge, registered onto the APB outputs
  typedef struct packed {
    logic [31:0] rdata;
    logic        slverr;
  } apb_rsp_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO; head is read combinationally from storage.
// A push while full is accepted only when a pop happens on the same edge.
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     apb_clk_in,
  input  logic                     apb_rstn_in,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointers carry one extra wrap bit so full/empty fall out of the difference
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; validity is tracked by the pointers
  always_ff @(posedge apb_clk_in) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign data  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/spi_fifo_reg.sv
// APB register front-end for an SPI core: config registers, TX/RX FIFOs,
// sticky/live interrupt status and a registered level interrupt.
module spi_fifo_reg
  import spi_pkg::*;
#(
  parameter int          APB_DATA_WIDTH = 32,
  parameter int          APB_ADDR_WIDTH = 32,
  parameter logic [31:0] SPI_REG_BASE   = 32'ha0300000,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          DATA_BITS      = 8
) (
  input  logic                      apb_clk_in,
  input  logic                      apb_rstn_in,
  input  logic [APB_ADDR_WIDTH-1:0] apb_addr_in,
  input  logic                      apb_psel_in,
  input  logic                      apb_penable_in,
  input  logic                      apb_write_in,
  input  logic [APB_DATA_WIDTH-1:0] apb_wdata_in,
`ifdef APB_WSTRB
  input  logic [APB_DATA_WIDTH/8-1:0] apb_strb_in,
`endif
  input  logic                      apb_slverr_in,
  output logic [APB_DATA_WIDTH-1:0] apb_rdata_out,
  output logic                      apb_ready_out,
  output logic                      apb_slverr_out,
  output logic [7:0]                spi_cr1_out,
  output logic                      spie_out,
  output logic                      sptie_out,
  output logic                      errie_out,
  output logic                      bidiroe_out,
  output logic                      spc0_out,
  output logic [2:0]                sppr_out,
  output logic [2:0]                spr_out,
  output logic [DATA_BITS-1:0]      tx_data_out,
  output logic                      tx_valid_out,
  input  logic                      tx_ready_in,
  input  logic [DATA_BITS-1:0]      rx_data_in,
  input  logic                      rx_valid_in,
  input  logic                      modf_in,
  output logic                      irq_out
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [APB_ADDR_WIDTH-1:0] BASE = APB_ADDR_WIDTH'(SPI_REG_BASE);

  apb_state_e state_q, state_d;
  logic       rsp_fire, setup_err, acc;

  logic [7:0] cr1, cr2, br, tx_thr, rx_thr;
  logic [5:0] ier, isr;
  logic [5:2] isr_st;
  logic       modf_q;

  logic [7:0]  off;
  logic [31:0] wd32, rd32;
  logic        strb_bad, addr_bad, ok, is_dr, reg_wr, dr_wr, dr_rd;
  logic        tx_push, tx_pop, tx_full, tx_empty, tx_ovf;
  logic        rx_push, rx_pop, rx_full, rx_empty, rx_ovr, rx_udf;
  logic [CW-1:0]        tx_cnt, rx_cnt;
  logic [DATA_BITS-1:0] rx_head;
  logic [8:0]           tx_cnt9, rx_cnt9;
  apb_rsp_t             rsp;
  logic                 unused_bits;

  // APB state register
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // Next state; a response fires on leaving ACCESS, or early out of a broken SETUP
  always_comb begin
    state_d   = state_q;
    rsp_fire  = 1'b0;
    setup_err = 1'b0;
    case (state_q)
      ST_IDLE:   if (apb_psel_in && !apb_penable_in) state_d = ST_SETUP;
      ST_SETUP: begin
        if (apb_psel_in && apb_penable_in) state_d = ST_ACCESS;
        else begin
          state_d   = ST_DONE;
          rsp_fire  = 1'b1;
          setup_err = 1'b1;
        end
      end
      ST_ACCESS: begin
        state_d  = ST_DONE;
        rsp_fire = 1'b1;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

`ifdef APB_WSTRB
  assign strb_bad = apb_write_in & ~apb_strb_in[0];
  assign unused_bits = ^{apb_strb_in, wd32};
`else
  assign strb_bad = 1'b0;
  assign unused_bits = ^wd32;
`endif

  assign acc  = (state_q == ST_ACCESS);
  assign off  = apb_addr_in[7:0];
  assign wd32 = 32'(apb_wdata_in);

  assign addr_bad = (apb_addr_in[APB_ADDR_WIDTH-1:8] != BASE[APB_ADDR_WIDTH-1:8]) |
                    (off > OFF_MAX) | (off[1:0] != 2'b00) |
                    (apb_write_in & ((off == OFF_SR) | (off == OFF_LVL))) |
                    apb_slverr_in | strb_bad;

  assign ok     = acc & ~addr_bad;
  assign is_dr  = (off == OFF_DR);
  assign reg_wr = ok & apb_write_in;
  assign dr_wr  = reg_wr & is_dr;
  assign dr_rd  = ok & ~apb_write_in & is_dr;

  // FIFO handshakes; a full FIFO still accepts a push when it pops on the same edge
  assign tx_pop  = tx_valid_out & tx_ready_in;
  assign tx_ovf  = dr_wr & tx_full & ~tx_pop;
  assign tx_push = dr_wr & ~tx_ovf;
  assign rx_pop  = dr_rd & ~rx_empty;
  assign rx_udf  = dr_rd & rx_empty;
  assign rx_ovr  = rx_valid_in & rx_full & ~rx_pop;
  assign rx_push = rx_valid_in & ~rx_ovr;

  spi_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .apb_clk_in(apb_clk_in), .apb_rstn_in(apb_rstn_in),
    .push(tx_push), .wr_data(wd32[DATA_BITS-1:0]), .pop(tx_pop),
    .data(tx_data_out), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
  );

  spi_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .apb_clk_in(apb_clk_in), .apb_rstn_in(apb_rstn_in),
    .push(rx_push), .wr_data(rx_data_in), .pop(rx_pop),
    .data(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
  );

  assign tx_valid_out = ~tx_empty;
  assign tx_cnt9 = 9'(tx_cnt);
  assign rx_cnt9 = 9'(rx_cnt);

  // Live level bits are recomputed every cycle; only [5:2] are stored
  assign isr[ISR_TX_LVL] = (tx_cnt9 <= {1'b0, tx_thr});
  assign isr[ISR_RX_LVL] = (rx_cnt9 >= {1'b0, rx_thr}) && (rx_cnt9 != 9'd0);
  assign isr[5:2]        = isr_st;

  // Read mux over a 32-bit view; unimplemented bits read as zero
  always_comb begin
    rd32 = '0;
    case (off)
      OFF_CR1: rd32[7:0] = cr1;
      OFF_CR2: rd32[7:0] = cr2;
      OFF_BR:  rd32[7:0] = br;
      OFF_SR: begin
        rd32[SR_TX_EMPTY] = tx_empty;
        rd32[SR_TX_FULL]  = tx_full;
        rd32[SR_RX_EMPTY] = rx_empty;
        rd32[SR_RX_FULL]  = rx_full;
      end
      OFF_DR:  rd32[DATA_BITS-1:0] = rx_head;
      OFF_LVL: begin
        rd32[LVL_TX_LSB +: 9] = tx_cnt9;
        rd32[LVL_RX_LSB +: 9] = rx_cnt9;
      end
      OFF_ISR: rd32[5:0] = isr;
      OFF_IER: rd32[5:0] = ier;
      OFF_THR: begin
        rd32[THR_TX_LSB +: 8] = tx_thr;
        rd32[THR_RX_LSB +: 8] = rx_thr;
      end
      default: rd32 = '0;
    endcase
  end

  // Response for the access completing at this edge
  always_comb begin
    rsp.slverr = setup_err | (acc & addr_bad) | tx_ovf | rx_udf;
    rsp.rdata  = (ok && !apb_write_in && !rx_udf) ? rd32 : 32'h0;
  end

  // Registered APB response, held for the single DONE cycle
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      apb_ready_out  <= 1'b0;
      apb_slverr_out <= 1'b0;
      apb_rdata_out  <= '0;
    end else begin
      apb_ready_out  <= rsp_fire;
      apb_slverr_out <= rsp_fire & rsp.slverr;
      apb_rdata_out  <= rsp_fire ? APB_DATA_WIDTH'(rsp.rdata) : '0;
    end
  end

  // Config register writes
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      cr1    <= CR1_RST;
      cr2    <= '0;
      br     <= '0;
      ier    <= '0;
      tx_thr <= '0;
      rx_thr <= RX_THR_RST;
    end else if (reg_wr) begin
      case (off)
        OFF_CR1: cr1 <= wd32[7:0];
        OFF_CR2: cr2 <= wd32[7:0] & CR2_MASK;
        OFF_BR:  br  <= wd32[7:0] & BR_MASK;
        OFF_IER: ier <= wd32[5:0];
        OFF_THR: begin
          tx_thr <= wd32[THR_TX_LSB +: 8];
          rx_thr <= wd32[THR_RX_LSB +: 8];
        end
        default: ;
      endcase
    end
  end

  // Sticky status: W1C clears, but a same-edge set event wins
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      isr_st <= '0;
      modf_q <= 1'b0;
    end else begin
      modf_q <= modf_in;
      isr_st <= (isr_st & ~((reg_wr && off == OFF_ISR) ? wd32[5:2] : 4'h0)) |
                {modf_in & ~modf_q, rx_udf, tx_ovf, rx_ovr};
    end
  end

  // Level interrupt, one cycle behind the masked status
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) irq_out <= 1'b0;
    else              irq_out <= |(isr & ier);
  end

  assign spi_cr1_out = cr1;
  assign spie_out    = cr2[CR2_SPIE];
  assign sptie_out   = cr2[CR2_SPTIE];
  assign errie_out   = cr2[CR2_ERRIE];
  assign bidiroe_out = cr2[CR2_BIDIROE];
  assign spc0_out    = cr2[CR2_SPC0];
  assign sppr_out    = br[BR_SPPR_LSB +: 3];
  assign spr_out     = br[BR_SPR_LSB +: 3];

endmodule

// File: tb/tb_spi_fifo_reg.sv
// Scoreboard bench: APB tasks queue the expected response, a monitor pops and
// compares on every apb_ready_out; a second monitor checks the TX stream.
module tb_spi_fifo_reg;
  import spi_pkg::*;

  localparam logic [31:0] B = 32'ha0300000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        psel = 1'b0, penable = 1'b0, write = 1'b0, slverr_in = 1'b0;
  logic [31:0] rdata;
  logic        ready, slverr;
  logic [7:0]  cr1;
  logic        spie, sptie, errie, bidiroe, spc0;
  logic [2:0]  sppr, spr;
  logic [7:0]  tx_data, rx_data = '0;
  logic        tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, modf = 1'b0, irq;
`ifdef APB_WSTRB
  logic [3:0]  strb = 4'hF;
`endif

  always #5 clk = ~clk;

  spi_fifo_reg #(.FIFO_DEPTH(4)) dut (
    .apb_clk_in(clk), .apb_rstn_in(rstn),
    .apb_addr_in(addr), .apb_psel_in(psel), .apb_penable_in(penable),
    .apb_write_in(write), .apb_wdata_in(wdata),
`ifdef APB_WSTRB
    .apb_strb_in(strb),
`endif
    .apb_slverr_in(slverr_in),
    .apb_rdata_out(rdata), .apb_ready_out(ready), .apb_slverr_out(slverr),
    .spi_cr1_out(cr1), .spie_out(spie), .sptie_out(sptie), .errie_out(errie),
    .bidiroe_out(bidiroe), .spc0_out(spc0), .sppr_out(sppr), .spr_out(spr),
    .tx_data_out(tx_data), .tx_valid_out(tx_valid), .tx_ready_in(tx_ready),
    .rx_data_in(rx_data), .rx_valid_in(rx_valid), .modf_in(modf),
    .irq_out(irq)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    string       tag;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] txq[$];
  exp_t       me;
  logic [7:0] tx_exp;
  logic       ready_prev = 1'b0;
  int         checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, act, exp);
    end
  endtask

  // mode: 0 normal, 1 penable held low, 2 apb_slverr_in high, 3 rx_valid pulse at the access edge
  task automatic apb(input string tag, input logic [7:0] off, input logic wr,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                     input int mode = 0, input logic [31:0] base = B);
    exp_t e;
    logic got;
    e.rdata = exp_rd; e.slverr = exp_err; e.tag = tag;
    sbq.push_back(e);
    @(posedge clk); #1;
    addr = base + {24'h0, off}; write = wr; wdata = wd;
    psel = 1'b1; penable = 1'b0; slverr_in = (mode == 2);
    @(posedge clk); #1;
    penable = (mode != 1);
    if (mode == 3) begin
      @(posedge clk); #1;
      rx_data = 8'hEE; rx_valid = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = ready;
    end
    rx_valid = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_timeout got=no_ready expected=ready", tag);
      void'(sbq.pop_back());
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; slverr_in = 1'b0;
  endtask

  task automatic rx_frames(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1; rx_data = first + 8'(i);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // APB response monitor
  always @(negedge clk) begin
    if (ready) begin
      checks++;
      if (ready_prev) begin
        failures++;
        $display("FAIL ready_width got=2+cycles expected=1");
      end
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rsp got rdata=%h slverr=%b expected=none", rdata, slverr);
      end else begin
        me = sbq.pop_front();
        checks++;
        if (rdata !== me.rdata || slverr !== me.slverr) begin
          failures++;
          $display("FAIL %s got rdata=%h slverr=%b expected rdata=%h slverr=%b",
                   me.tag, rdata, slverr, me.rdata, me.slverr);
        end
      end
    end
    ready_prev = ready;
  end

  // TX stream monitor
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      checks++;
      if (txq.size() == 0) begin
        failures++;
        $display("FAIL tx_unexpected got=%h expected=none", tx_data);
      end else begin
        tx_exp = txq.pop_front();
        if (tx_data !== tx_exp) begin
          failures++;
          $display("FAIL tx_data got=%h expected=%h", tx_data, tx_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic done;
    // Reset values
    repeat (3) @(posedge clk); #1;
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_slverr", {31'h0, slverr}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_cr1", {24'h0, cr1}, 32'h10);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_txv", {31'h0, tx_valid}, 32'h0);
    chk("rst_br", {26'h0, sppr, spr}, 32'h0);
    rstn = 1'b1;
    apb("rst_sr",  OFF_SR,  0, 0, 32'h5, 0);
    apb("rst_thr", OFF_THR, 0, 0, 32'h0001_0000, 0);
    apb("rst_isr", OFF_ISR, 0, 0, 32'h1, 0);
    apb("rst_cr1_rd", OFF_CR1, 0, 0, 32'h10, 0);

    // Register write/read
    apb("cr1_wr", OFF_CR1, 1, 32'h5A, 0, 0);
    apb("cr1_rd", OFF_CR1, 0, 0, 32'h5A, 0);
    chk("cr1_out", {24'h0, cr1}, 32'h5A);
    apb("cr2_wr", OFF_CR2, 1, 32'hFF, 0, 0);
    apb("cr2_rd", OFF_CR2, 0, 0, 32'hE3, 0);
    chk("cr2_out", {27'h0, spie, sptie, errie, bidiroe, spc0}, 32'h1F);
    apb("br_wr", OFF_BR, 1, 32'hFF, 0, 0);
    apb("br_rd", OFF_BR, 0, 0, 32'h77, 0);
    chk("br_out", {26'h0, sppr, spr}, 32'h3F);

    // Bad accesses leave registers untouched
    apb("bad_off24", 8'h24, 0, 0, 0, 1);
    apb("bad_unal",  8'h02, 1, 32'h33, 0, 1);
    apb("bad_sr_wr", OFF_SR, 1, 32'hF, 0, 1);
    apb("sr_after",  OFF_SR, 0, 0, 32'h5, 0);
    apb("bad_base",  OFF_CR1, 1, 32'h44, 0, 1, 0, 32'ha0310000);
    apb("bad_pen",   OFF_CR1, 1, 32'h77, 0, 1, 1);
    apb("bad_slvin", OFF_CR1, 1, 32'h66, 0, 1, 2);
    apb("cr1_kept",  OFF_CR1, 0, 0, 32'h5A, 0);

    // TX overflow then drain
    for (int i = 0; i < 4; i++) apb("tx_wr", OFF_DR, 1, 32'h11 + i, 0, 0);
    apb("tx_ovf_wr", OFF_DR, 1, 32'h15, 0, 1);
    apb("tx_lvl", OFF_LVL, 0, 0, 32'h4, 0);
    apb("tx_sr",  OFF_SR,  0, 0, 32'h6, 0);
    apb("tx_isr", OFF_ISR, 0, 0, 32'h08, 0);
    for (int i = 0; i < 4; i++) txq.push_back(8'h11 + 8'(i));
    @(posedge clk); #1; tx_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = !tx_valid;
    end
    chk("tx_drained", {31'h0, done}, 32'h1);
    chk("tx_q_left", txq.size(), 32'h0);
    apb("isr_drain", OFF_ISR, 0, 0, 32'h09, 0);
    apb("isr_w1c8",  OFF_ISR, 1, 32'h08, 0, 0);
    apb("isr_clr8",  OFF_ISR, 0, 0, 32'h01, 0);
    apb("isr_w1c3",  OFF_ISR, 1, 32'h03, 0, 0);
    apb("isr_live",  OFF_ISR, 0, 0, 32'h01, 0);

    // RX overflow and underflow
    rx_frames(8'hA0, 5);
    apb("rx_isr", OFF_ISR, 0, 0, 32'h07, 0);
    apb("rx_sr",  OFF_SR,  0, 0, 32'h9, 0);
    apb("rx_lvl", OFF_LVL, 0, 0, 32'h0004_0000, 0);
    for (int i = 0; i < 4; i++) apb("rx_rd", OFF_DR, 0, 0, 32'hA0 + i, 0);
    apb("rx_udf_rd", OFF_DR, 0, 0, 0, 1);
    apb("rx_isr2", OFF_ISR, 0, 0, 32'h15, 0);

    // Interrupt clear, and set winning over a coincident W1C
    apb("ier_wr", OFF_IER, 1, 32'h04, 0, 0);
    chk("irq_on", {31'h0, irq}, 32'h1);
    apb("isr_w1c4", OFF_ISR, 1, 32'h04, 0, 0);
    chk("irq_off", {31'h0, irq}, 32'h0);
    apb("isr_clr4", OFF_ISR, 0, 0, 32'h11, 0);
    rx_frames(8'hB0, 4);
    apb("isr_full", OFF_ISR, 0, 0, 32'h13, 0);
    apb("isr_w1c_race", OFF_ISR, 1, 32'h04, 0, 0, 3);
    apb("isr_setwin", OFF_ISR, 0, 0, 32'h17, 0);
    chk("irq_again", {31'h0, irq}, 32'h1);

    // Reset in the middle of a DR write access
    tx_ready = 1'b0;
    apb("dr_pre",  OFF_DR,  1, 32'h99, 0, 0);
    apb("lvl_pre", OFF_LVL, 0, 0, 32'h0004_0001, 0);
    @(posedge clk); #1;
    addr = B + 32'h10; write = 1'b1; wdata = 32'h77; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; rstn = 1'b0;
    #2;
    chk("abort_ready", {31'h0, ready}, 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    chk("abort_irq", {31'h0, irq}, 32'h0);
    chk("abort_cr1", {24'h0, cr1}, 32'h10);
    chk("abort_txv", {31'h0, tx_valid}, 32'h0);
    psel = 1'b0; penable = 1'b0; write = 1'b0;
    @(posedge clk); #1; rstn = 1'b1;
    apb("post_lvl", OFF_LVL, 0, 0, 32'h0, 0);
    apb("post_sr",  OFF_SR,  0, 0, 32'h5, 0);
    apb("post_ier", OFF_IER, 0, 0, 32'h0, 0);
    apb("post_isr", OFF_ISR, 0, 0, 32'h1, 0);

    repeat (4) @(posedge clk); #1;
    chk("sb_drain", sbq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
